// File: rtl/wb_slave_router.sv
// Wishbone classic router: forwards one master request to a UART or RAM slave,
// answers its own status register, and times out slaves that never ack.
module wb_slave_router #(
  parameter logic [7:0]  UART_BASE = 8'h30,
  parameter logic [7:0]  RAM_BASE  = 8'h38,
  parameter logic [7:0]  STAT_BASE = 8'h3F,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        uart_cyc_o,
  output logic        uart_stb_o,
  output logic        ram_cyc_o,
  output logic        ram_stb_o,
  input  logic        uart_ack_i,
  input  logic        ram_ack_i,
  input  logic [31:0] uart_dat_i,
  input  logic [31:0] ram_dat_i,
  output logic        err_irq_o,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken only in IDLE when cyc&stb are high at an edge;
  // the master holds cyc/stb until it sees the single-cycle wbs_ack_o, and a
  // slave transfer completes at the edge where its ack is high while strobed.
  typedef enum logic [1:0] {IDLE = 2'd0, FWD_UART = 2'd1, FWD_RAM = 2'd2, RESP = 2'd3} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [15:0] unmapped_cnt;
  logic [15:0] timeout_cnt;

  logic        req_take, hit_uart, hit_ram, hit_stat;
  logic        in_fwd, fwd_ack, timeout_hit;
  logic        inc_unmapped, clr_unmapped, inc_timeout, clr_timeout, stat_wr;
  logic [31:0] fwd_dat;

  assign req_take     = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign hit_uart     = (wbs_adr_i[31:24] == UART_BASE);
  assign hit_ram      = !hit_uart && (wbs_adr_i[31:24] == RAM_BASE);
  assign hit_stat     = !hit_uart && !hit_ram && (wbs_adr_i[31:24] == STAT_BASE);
  assign in_fwd       = (state == FWD_UART) || (state == FWD_RAM);
  assign fwd_ack      = (state == FWD_UART) ? uart_ack_i : ram_ack_i;
  assign fwd_dat      = (state == FWD_UART) ? uart_dat_i : ram_dat_i;
  assign timeout_hit  = in_fwd && wbs_cyc_i && !fwd_ack && (wait_cnt == WAIT_LAST);
  assign stat_wr      = req_take && hit_stat && wbs_we_i;
  assign inc_unmapped = req_take && !hit_uart && !hit_ram && !hit_stat;
  assign clr_unmapped = stat_wr && wbs_sel_i[0];
  assign inc_timeout  = timeout_hit;
  assign clr_timeout  = stat_wr && wbs_sel_i[2];

  assign err_irq_o = (unmapped_cnt != 16'd0) || (timeout_cnt != 16'd0);
  assign dbg_state = state;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      s_adr_o    <= '0;
      s_dat_o    <= '0;
      s_sel_o    <= '0;
      s_we_o     <= 1'b0;
      uart_cyc_o <= 1'b0;
      uart_stb_o <= 1'b0;
      ram_cyc_o  <= 1'b0;
      ram_stb_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_take) begin
            s_adr_o  <= wbs_adr_i;
            s_dat_o  <= wbs_dat_i;
            s_sel_o  <= wbs_sel_i;
            s_we_o   <= wbs_we_i;
            wait_cnt <= '0;
            if (hit_uart) begin
              state      <= FWD_UART;
              uart_cyc_o <= 1'b1;
              uart_stb_o <= 1'b1;
            end else if (hit_ram) begin
              state     <= FWD_RAM;
              ram_cyc_o <= 1'b1;
              ram_stb_o <= 1'b1;
            end else if (hit_stat) begin
              state     <= RESP;
              wbs_dat_o <= {timeout_cnt, unmapped_cnt};
            end else begin
              state     <= RESP;
              wbs_dat_o <= '0;
            end
          end
        end
        FWD_UART, FWD_RAM: begin
          // Abort beats ack: with cyc gone there is nobody to answer.
          if (!wbs_cyc_i) begin
            state      <= IDLE;
            uart_cyc_o <= 1'b0;
            uart_stb_o <= 1'b0;
            ram_cyc_o  <= 1'b0;
            ram_stb_o  <= 1'b0;
          end else if (fwd_ack || timeout_hit) begin
            state      <= RESP;
            wbs_ack_o  <= 1'b1;
            wbs_dat_o  <= fwd_ack ? fwd_dat : (32'hDEAD_0000 | {16'h0000, s_adr_o[15:0]});
            uart_cyc_o <= 1'b0;
            uart_stb_o <= 1'b0;
            ram_cyc_o  <= 1'b0;
            ram_stb_o  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          // Entered with ack already set from a slave; local accesses raise it here.
          if (wbs_ack_o) begin
            wbs_ack_o <= 1'b0;
            state     <= IDLE;
          end else begin
            wbs_ack_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear has priority over increment; both saturate at all-ones.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      unmapped_cnt <= '0;
      timeout_cnt  <= '0;
    end else begin
      if (clr_unmapped)
        unmapped_cnt <= '0;
      else if (inc_unmapped && (unmapped_cnt != 16'hFFFF))
        unmapped_cnt <= unmapped_cnt + 16'd1;
      if (clr_timeout)
        timeout_cnt <= '0;
      else if (inc_timeout && (timeout_cnt != 16'hFFFF))
        timeout_cnt <= timeout_cnt + 16'd1;
    end
  end

endmodule
